pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Hazard and sequencing controller for the 5-stage pipeline. It drives the enable/flush inputs of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB buffers. It resolves RAW data hazards by stalling, since the pipeline has no forwarding. It redirects fetch on branches and jumps resolved in MEM, and freezes the pipe while data memory is busy, with a stall/flush performance counter pair and a memory-wait watchdog.

## Interface
- CNT_W, 16, width of stall/flush performance counters (saturating)
- MAX_WAIT, 15, consecutive MWAIT cycles that trigger mem_timeout
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- id_rs, id_rt  in  6 each  source register addresses of instruction in ID
- id_uses_rs, id_uses_rt  in  1 each  ID instruction actually reads that source
- ex_rd, mem_rd  in  6 each  destination register in EX and MEM stages
- ex_regwrite, mem_regwrite  in  1 each  RegWrite control of EX and MEM stages
- mem_brz, mem_brn, mem_jump, mem_jump_mem  in  1 each  branch/jump controls from EX/MEM
- mem_z, mem_n  in  1 each  Z/N flags from EX/MEM
- mem_memread, mem_memwrite  in  1 each  memory access in MEM stage
- dmem_ready  in  1  data memory completes access this cycle
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register load enables
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  load a bubble (all controls zero) instead of input
- pc_sel  out  2  next-PC select: 0 = PC+1, 1 = EX/MEM pc_plus_imm, 2 = data memory read data (jump_mem)
- state  out  2  current FSM state
- stall_count, flush_count  out  CNT_W each  performance counters
- mem_timeout  out  1  sticky watchdog error

## Operation
- Decision per cycle uses the fixed priority below, evaluated combinationally from inputs. The registered state only records the previous cycle's decision.
- P1, memory busy: (mem_memread | mem_memwrite | mem_jump_mem) & !dmem_ready. pc/ifid/idex/exmem en = 0, memwb_flush = 1, memwb_en = 1. Next state MWAIT.
- P2, redirect: taken = (mem_brz & mem_z) | (mem_brn & mem_n) | mem_jump | mem_jump_mem. All en = 1, ifid/idex/exmem_flush = 1. pc_sel = 2 if mem_jump_mem, else 1. flush_count += 1. Next state REDIR.
- P3, data hazard: any of (id_uses_rs & rs == ex_rd & ex_regwrite), (id_uses_rs & rs == mem_rd & mem_regwrite), and the same two terms for rt. Register 0 is not special. pc_en = ifid_en = 0, idex_flush = 1, exmem/memwb advance. stall_count += 1. Next state DSTALL.
- WB-stage writers never cause a stall; the register file is write-through.
- Otherwise: all en = 1, no flush, pc_sel = 0. Next state RUN.
- A taken branch suppresses the hazard stall in the same cycle, because the ID instruction is flushed.
- FSM states (package enum): RUN = 0, DSTALL = 1, MWAIT = 2, REDIR = 3. Any state can go to any state per the priority above.
- Watchdog: wait_cnt increments each cycle spent in MWAIT and clears on any other next state. mem_timeout sets when wait_cnt == MAX_WAIT and clears only by rst. It does not alter pipeline control.
- Counters saturate at 2^CNT_W - 1 and do not wrap.

## Timing
- Control outputs are combinational from current inputs. state, counters, wait_cnt and mem_timeout update on the rising edge of clk.
- Redirect penalty: 3 bubbles. The new PC is loaded on the same edge that the flushes take effect.
- Load-use distance 1: 2 stall cycles. Distance 2: 1 stall cycle.
- While rst is high, regardless of inputs:
  - all en = 0 and all flush = 1;
  - pc_sel = 0;
  - state = RUN;
  - counters, wait_cnt and mem_timeout = 0.
- Reset mid-MWAIT or mid-stall abandons the operation immediately. The first cycle after deassertion is evaluated normally.
- P1 concurrent with a taken jump_mem: P1 wins. The redirect takes effect in the cycle dmem_ready rises.

## Structure
- pipe_ctrl_pkg: state enum, pc_sel encodings (PCSEL_SEQ/PCSEL_BR/PCSEL_MEM), bubble-control constant.
- One sub-module, sat_counter (parameter width; inc, clear; async reset). It is instantiated for stall_count, flush_count and wait_cnt.

## Test plan
- Load r5 in EX, ID reads r5 via rs -> pc_en = 0, idex_flush = 1 for 2 cycles, stall_count = 2, state DSTALL then RUN.
- mem_brz = 1, mem_z = 1, no hazard -> ifid/idex/exmem_flush = 1, pc_sel = 1, flush_count = 1. With mem_z = 0 -> no flush, pc_sel = 0.
- mem_jump_mem = 1 with dmem_ready = 0 for 3 cycles then 1 -> 3 cycles of freeze plus memwb_flush, then pc_sel = 2 with flushes. No timeout.
- dmem_ready held 0 for 16 cycles with mem_memread = 1 -> mem_timeout rises after MAX_WAIT = 15 MWAIT cycles and stays 1 after dmem_ready returns.
- Taken branch plus simultaneous EX hazard -> redirect only, stall_count unchanged.
- rst asserted asynchronously mid-MWAIT -> outputs go to reset values before the next edge, counters = 0, and after release state = RUN.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the 5-stage pipeline hazard/sequencing controller:
// FSM state encoding, next-PC select codes and the per-stage control bundle.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DSTALL = 2'd1,
    MWAIT  = 2'd2,
    REDIR  = 2'd3
  } state_e;

  localparam logic [1:0] PCSEL_SEQ = 2'd0;
  localparam logic [1:0] PCSEL_BR  = 2'd1;
  localparam logic [1:0] PCSEL_MEM = 2'd2;

  typedef struct packed {
    logic       pc_en;
    logic       ifid_en;
    logic       idex_en;
    logic       exmem_en;
    logic       memwb_en;
    logic       ifid_flush;
    logic       idex_flush;
    logic       exmem_flush;
    logic       memwb_flush;
    logic [1:0] pc_sel;
  } ctrl_t;

  // Everything frozen and every buffer loading a bubble.
  localparam ctrl_t CTRL_BUBBLE = ctrl_t'(11'b00000_1111_00);
  // Free-running pipe: all stages advance, fetch PC+1.
  localparam ctrl_t CTRL_RUN    = ctrl_t'(11'b11111_0000_00);

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller: stalls on RAW hazards, redirects fetch on
// MEM-resolved branches/jumps, freezes on data-memory waits, counts and watches.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       id_rs,
  input  logic [5:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [5:0]       ex_rd,
  input  logic [5:0]       mem_rd,
  input  logic             ex_regwrite,
  input  logic             mem_regwrite,
  input  logic             mem_brz,
  input  logic             mem_brn,
  input  logic             mem_jump,
  input  logic             mem_jump_mem,
  input  logic             mem_z,
  input  logic             mem_n,
  input  logic             mem_memread,
  input  logic             mem_memwrite,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic [1:0]       pc_sel,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic             mem_timeout
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  logic        mem_busy;
  logic        taken;
  logic        hazard;
  ctrl_t       ctrl;
  state_e      state_q;
  state_e      state_d;
  logic        mem_timeout_q;
  logic        mem_timeout_d;
  logic [WAIT_W-1:0] wait_cnt;

  // Fixed-priority decision: memory wait > redirect > RAW stall > run.
  always_comb begin
    mem_busy = (mem_memread | mem_memwrite | mem_jump_mem) & ~dmem_ready;
    taken    = (mem_brz & mem_z) | (mem_brn & mem_n) | mem_jump | mem_jump_mem;
    hazard   = (id_uses_rs & (id_rs == ex_rd)  & ex_regwrite)
             | (id_uses_rs & (id_rs == mem_rd) & mem_regwrite)
             | (id_uses_rt & (id_rt == ex_rd)  & ex_regwrite)
             | (id_uses_rt & (id_rt == mem_rd) & mem_regwrite);

    ctrl        = CTRL_RUN;
    ctrl.pc_sel = PCSEL_SEQ;
    state_d     = RUN;

    if (mem_busy) begin
      ctrl             = '0;
      ctrl.memwb_en    = 1'b1;
      ctrl.memwb_flush = 1'b1;
      state_d          = MWAIT;
    end else if (taken) begin
      ctrl.ifid_flush  = 1'b1;
      ctrl.idex_flush  = 1'b1;
      ctrl.exmem_flush = 1'b1;
      ctrl.pc_sel      = mem_jump_mem ? PCSEL_MEM : PCSEL_BR;
      state_d          = REDIR;
    end else if (hazard) begin
      ctrl.pc_en      = 1'b0;
      ctrl.ifid_en    = 1'b0;
      ctrl.idex_flush = 1'b1;
      state_d         = DSTALL;
    end

    // Reset overrides combinationally so the pipe is quiesced without a clock.
    if (rst) begin
      ctrl = CTRL_BUBBLE;
    end
  end

  assign pc_en       = ctrl.pc_en;
  assign ifid_en     = ctrl.ifid_en;
  assign idex_en     = ctrl.idex_en;
  assign exmem_en    = ctrl.exmem_en;
  assign memwb_en    = ctrl.memwb_en;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_flush  = ctrl.idex_flush;
  assign exmem_flush = ctrl.exmem_flush;
  assign memwb_flush = ctrl.memwb_flush;
  assign pc_sel      = ctrl.pc_sel;

  assign mem_timeout_d = mem_timeout_q | (wait_cnt == WAIT_W'(MAX_WAIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign state       = state_q;
  assign mem_timeout = mem_timeout_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (state_d == DSTALL),
    .clear (1'b0),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (state_d == REDIR),
    .clear (1'b0),
    .count (flush_count)
  );

  // Consecutive memory-wait cycles; any other decision restarts the run.
  sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (state_d == MWAIT),
    .clear (state_d != MWAIT),
    .count (wait_cnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: stimulus pushes hand-derived expectations,
// a negedge monitor pops and compares control, state, counters and watchdog.
module tb_pipeline_ctrl;

  localparam int unsigned CNT_W    = 16;
  localparam int unsigned MAX_WAIT = 15;

  localparam logic [10:0] RUN_C  = 11'b11111_0000_00;
  localparam logic [10:0] HAZ_C  = 11'b00111_0100_00;
  localparam logic [10:0] BUSY_C = 11'b00001_0001_00;
  localparam logic [10:0] BR_C   = 11'b11111_1110_01;
  localparam logic [10:0] JM_C   = 11'b11111_1110_10;
  localparam logic [10:0] RST_C  = 11'b00000_1111_00;

  logic clk, rst;
  logic [5:0] id_rs, id_rt, ex_rd, mem_rd;
  logic id_uses_rs, id_uses_rt, ex_regwrite, mem_regwrite;
  logic mem_brz, mem_brn, mem_jump, mem_jump_mem, mem_z, mem_n;
  logic mem_memread, mem_memwrite, dmem_ready;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic [1:0] pc_sel, state;
  logic [CNT_W-1:0] stall_count, flush_count;
  logic mem_timeout;

  pipeline_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .ex_regwrite(ex_regwrite), .mem_regwrite(mem_regwrite),
    .mem_brz(mem_brz), .mem_brn(mem_brn), .mem_jump(mem_jump), .mem_jump_mem(mem_jump_mem),
    .mem_z(mem_z), .mem_n(mem_n), .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .dmem_ready(dmem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .memwb_flush(memwb_flush), .pc_sel(pc_sel), .state(state),
    .stall_count(stall_count), .flush_count(flush_count), .mem_timeout(mem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [10:0]      ctrl;
    logic [1:0]       st;
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] flush;
    logic             tmo;
  } exp_t;

  exp_t sb[$];
  exp_t m;
  int checks = 0;
  int errors = 0;
  logic [10:0] act_ctrl;

  assign act_ctrl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                     ifid_flush, idex_flush, exmem_flush, memwb_flush, pc_sel};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: the DUT presents a decision every cycle; compare mid-cycle.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      m = sb.pop_front();
      chk("ctrl",        32'(act_ctrl),    32'(m.ctrl));
      chk("state",       32'(state),       32'(m.st));
      chk("stall_count", 32'(stall_count), 32'(m.stall));
      chk("flush_count", 32'(flush_count), 32'(m.flush));
      chk("mem_timeout", 32'(mem_timeout), 32'(m.tmo));
    end
  end

  // Queue the expectation for the current cycle's inputs, then advance.
  task automatic step(input logic [10:0] c, input logic [1:0] s, input int st,
                      input int fl, input logic to);
    exp_t e;
    e.ctrl  = c;
    e.st    = s;
    e.stall = CNT_W'(st);
    e.flush = CNT_W'(fl);
    e.tmo   = to;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs = '0; id_rt = '0; ex_rd = '0; mem_rd = '0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_regwrite = 1'b0; mem_regwrite = 1'b0;
    mem_brz = 1'b0; mem_brn = 1'b0; mem_jump = 1'b0; mem_jump_mem = 1'b0;
    mem_z = 1'b0; mem_n = 1'b0; mem_memread = 1'b0; mem_memwrite = 1'b0;
    dmem_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "bench time limit expired");
  end

  initial begin
    // Reset held with busy/hazard inputs active: outputs must be the bubble.
    rst = 1'b1;
    idle();
    mem_memread = 1'b1; dmem_ready = 1'b0;
    id_rs = 6'd5; id_uses_rs = 1'b1; ex_rd = 6'd5; ex_regwrite = 1'b1;
    @(posedge clk); #1;
    step(RST_C, 2'd0, 0, 0, 1'b0);
    step(RST_C, 2'd0, 0, 0, 1'b0);
    rst = 1'b0;
    idle();
    step(RUN_C, 2'd0, 0, 0, 1'b0);

    // Load-use distance 1 via rs: two stall cycles.
    id_rs = 6'd5; id_uses_rs = 1'b1; ex_rd = 6'd5; ex_regwrite = 1'b1;
    step(HAZ_C, 2'd0, 0, 0, 1'b0);
    ex_regwrite = 1'b0; mem_rd = 6'd5; mem_regwrite = 1'b1;
    step(HAZ_C, 2'd1, 1, 0, 1'b0);
    idle();
    step(RUN_C, 2'd1, 2, 0, 1'b0);
    step(RUN_C, 2'd0, 2, 0, 1'b0);

    // Distance 2 via rt on register 0: one stall.
    id_rt = 6'd0; id_uses_rt = 1'b1; mem_rd = 6'd0; mem_regwrite = 1'b1;
    step(HAZ_C, 2'd0, 2, 0, 1'b0);
    idle();
    step(RUN_C, 2'd1, 3, 0, 1'b0);
    // Matching address but source unused / no writeback: no stall.
    id_rs = 6'd7; ex_rd = 6'd7; ex_regwrite = 1'b1;
    step(RUN_C, 2'd0, 3, 0, 1'b0);
    id_uses_rs = 1'b1; ex_regwrite = 1'b0;
    step(RUN_C, 2'd0, 3, 0, 1'b0);
    idle();

    // Branch on Z taken, then not taken.
    mem_brz = 1'b1; mem_z = 1'b1;
    step(BR_C, 2'd0, 3, 0, 1'b0);
    mem_z = 1'b0;
    step(RUN_C, 2'd3, 3, 1, 1'b0);
    idle();
    mem_brn = 1'b1; mem_n = 1'b1;
    step(BR_C, 2'd0, 3, 1, 1'b0);
    idle();
    step(RUN_C, 2'd3, 3, 2, 1'b0);
    step(RUN_C, 2'd0, 3, 2, 1'b0);

    // Taken branch with simultaneous EX hazard: redirect only.
    mem_brz = 1'b1; mem_z = 1'b1;
    id_rs = 6'd5; id_uses_rs = 1'b1; ex_rd = 6'd5; ex_regwrite = 1'b1;
    step(BR_C, 2'd0, 3, 2, 1'b0);
    idle();
    step(RUN_C, 2'd3, 3, 3, 1'b0);
    step(RUN_C, 2'd0, 3, 3, 1'b0);

    // jump_mem waits three cycles on memory, then redirects to loaded PC.
    mem_jump_mem = 1'b1; dmem_ready = 1'b0;
    step(BUSY_C, 2'd0, 3, 3, 1'b0);
    step(BUSY_C, 2'd2, 3, 3, 1'b0);
    step(BUSY_C, 2'd2, 3, 3, 1'b0);
    dmem_ready = 1'b1;
    step(JM_C, 2'd2, 3, 3, 1'b0);
    idle();
    step(RUN_C, 2'd3, 3, 4, 1'b0);
    mem_jump = 1'b1;
    step(BR_C, 2'd0, 3, 4, 1'b0);
    idle();
    mem_memwrite = 1'b1;
    step(RUN_C, 2'd3, 3, 5, 1'b0);
    idle();
    step(RUN_C, 2'd0, 3, 5, 1'b0);

    // Watchdog: 16 wait cycles, sticky timeout afterward.
    mem_memread = 1'b1; dmem_ready = 1'b0;
    step(BUSY_C, 2'd0, 3, 5, 1'b0);
    for (int i = 1; i < 16; i++) step(BUSY_C, 2'd2, 3, 5, 1'b0);
    dmem_ready = 1'b1;
    step(RUN_C, 2'd2, 3, 5, 1'b1);
    idle();
    step(RUN_C, 2'd0, 3, 5, 1'b1);

    // Asynchronous reset mid-wait: outputs and registers clear before the edge.
    mem_memread = 1'b1; dmem_ready = 1'b0;
    step(BUSY_C, 2'd0, 3, 5, 1'b1);
    step(BUSY_C, 2'd2, 3, 5, 1'b1);
    rst = 1'b1;
    step(RST_C, 2'd0, 0, 0, 1'b0);
    rst = 1'b0;
    step(BUSY_C, 2'd0, 0, 0, 1'b0);
    idle();
    step(RUN_C, 2'd2, 0, 0, 1'b0);
    id_rt = 6'd9; id_uses_rt = 1'b1; ex_rd = 6'd9; ex_regwrite = 1'b1;
    step(HAZ_C, 2'd0, 0, 0, 1'b0);
    idle();
    step(RUN_C, 2'd1, 1, 0, 1'b0);

    @(negedge clk); #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
